// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencer for the shared iterative multiply/divide unit.
//
// Takes one MUL*/DIV*/REM* request at a time over a valid/ready handshake,
// normalises operand signs, runs a radix-2 shift-add (mul) or restoring
// shift-subtract (div) loop, applies sign/width fix-up and holds the result
// until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Input side: in_valid/in_ready (in_ready only in IDLE).
// Output side: out_valid/out_ready (out_valid only in DONE, result stable
// while out_valid is high and out_ready is low). flush overrides both.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort; returns to IDLE next cycle
//   in_valid, in_ready  request handshake
//   src1, src2          operands (multiplicand/dividend, multiplier/divisor)
//   mul_valid, mul_signed[1:0], mul_res_lo     multiply controls
//   div_valid, div_signed[1:0], div_quotient   divide controls
//   inst_32             W-form: 32-bit operands, sign-extended 32-bit result
//   out_valid, out_ready, result               result handshake
//   busy                state != IDLE
//   dbg_state           current FSM state (debug observation)
//
// Build option: define MDU_FAST_ZERO_EN to finish zero-operand cases in PREP
// instead of running the full iteration loop (result values are identical).

module mdu_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            mul_valid,
    input  logic [1:0]      mul_signed,
    input  logic            mul_res_lo,
    input  logic            div_valid,
    input  logic [1:0]      div_signed,
    input  logic            div_quotient,
    input  logic            inst_32,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [2:0]      dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // W-form results are always the sign-extended low word.
    function automatic logic [XLEN-1:0] fit_w(input logic w32, input logic [XLEN-1:0] v);
        return w32 ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    logic [2:0]        r_state;
    logic [XLEN-1:0]   r_a, r_b, r_op, r_result;
    logic [2*XLEN-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_mul, r_sgn1, r_sgn2, r_lo, r_quot, r_w32, r_neg;

    // ---------------- request capture ----------------
    logic            w_start, w_sgn1_in, w_sgn2_in;
    logic [XLEN-1:0] w_src1_ext, w_src2_ext;

    assign w_start   = in_valid & in_ready & (mul_valid | div_valid);
    // mul wins when both request bits are set
    assign w_sgn1_in = mul_valid ? mul_signed[1] : div_signed[1];
    assign w_sgn2_in = mul_valid ? mul_signed[0] : div_signed[0];
    assign w_src1_ext = inst_32 ? (w_sgn1_in ? fit_w(1'b1, src1) : {{(XLEN-32){1'b0}}, src1[31:0]}) : src1;
    assign w_src2_ext = inst_32 ? (w_sgn2_in ? fit_w(1'b1, src2) : {{(XLEN-32){1'b0}}, src2[31:0]}) : src2;

    // ---------------- PREP ----------------
    logic            w_neg_a, w_neg_b, w_div_zero, w_div_ovf, w_fast_zero;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_min_neg, w_spec_val;

    // operands are already extended, so the top bit is the sign at either width
    assign w_neg_a    = r_sgn1 & r_a[XLEN-1];
    assign w_neg_b    = r_sgn2 & r_b[XLEN-1];
    assign w_abs_a    = w_neg_a ? -r_a : r_a;
    assign w_abs_b    = w_neg_b ? -r_b : r_b;
    assign w_min_neg  = r_w32 ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = ~r_is_mul & (r_b == '0);
    assign w_div_ovf  = ~r_is_mul & r_sgn1 & (r_a == w_min_neg) & (&r_b);
    assign w_spec_val = w_div_zero ? (r_quot ? {XLEN{1'b1}} : r_a)
                                   : (r_quot ? r_a : {XLEN{1'b0}});
`ifdef MDU_FAST_ZERO_EN
    assign w_fast_zero = r_is_mul ? ((r_a == '0) | (r_b == '0))
                                  : ((r_a == '0) & (r_b != '0));
`else
    assign w_fast_zero = 1'b0;
`endif

    // ---------------- ITER ----------------
    // Mul: r_acc = {partial sum, remaining multiplier bits}, shifted right.
    // Div: r_acc = {partial remainder, dividend bits / quotient bits}, shifted left.
    logic [XLEN:0]   w_sum, w_rem_sh;
    logic [XLEN-1:0] w_rem_sub;
    logic            w_rem_ge;

    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + ({1'b0, r_op} & {(XLEN+1){r_acc[0]}});
    assign w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_rem_ge  = w_rem_sh >= {1'b0, r_op};
    assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_op;

    // ---------------- FIX ----------------
    // A 32-iteration multiply leaves the product XLEN-32 bits above bit 0.
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_q, w_r, w_fix_val;

    assign w_prod    = r_w32 ? (r_acc >> (XLEN-32)) : r_acc;
    assign w_prod_s  = r_neg ? -w_prod : w_prod;
    assign w_q       = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_r       = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_fix_val = r_is_mul ? (r_lo ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN])
                                : (r_quot ? w_q : w_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_sgn1   <= 1'b0;
            r_sgn2   <= 1'b0;
            r_lo     <= 1'b0;
            r_quot   <= 1'b0;
            r_w32    <= 1'b0;
            r_neg    <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_a      <= w_src1_ext;
                    r_b      <= w_src2_ext;
                    r_is_mul <= mul_valid;
                    r_sgn1   <= w_sgn1_in;
                    r_sgn2   <= w_sgn2_in;
                    r_lo     <= mul_res_lo;
                    r_quot   <= div_quotient;
                    r_w32    <= inst_32;
                    r_state  <= S_PREP;
                end
                S_PREP: begin
                    // remainder takes the dividend's sign, everything else the xor
                    r_neg <= (r_is_mul | r_quot) ? (w_neg_a ^ w_neg_b) : w_neg_a;
                    if (w_div_zero | w_div_ovf) begin
                        r_result <= fit_w(r_w32, w_spec_val);
                        r_state  <= S_DONE;
                    end else if (w_fast_zero) begin
                        r_result <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt   <= r_w32 ? CNT_W'(31) : CNT_W'(XLEN-1);
                        r_op    <= r_is_mul ? w_abs_a : w_abs_b;
                        // W-form divide: move the 32 dividend bits to the top
                        r_acc   <= r_is_mul ? {{XLEN{1'b0}}, w_abs_b}
                                            : {{XLEN{1'b0}}, (r_w32 ? (w_abs_a << 32) : w_abs_a)};
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (r_is_mul)
                        r_acc <= {w_sum, r_acc[XLEN-1:1]};
                    else
                        r_acc <= {(w_rem_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]),
                                  r_acc[XLEN-2:0], w_rem_ge};
                    if (r_cnt == '0)
                        r_state <= S_FIX;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_result <= fit_w(r_w32, w_fix_val);
                    r_state  <= S_DONE;
                end
                S_DONE: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] src1 = '0;
  logic [XLEN-1:0] src2 = '0;
  logic            mul_valid = 1'b0;
  logic [1:0]      mul_signed = 2'b00;
  logic            mul_res_lo = 1'b0;
  logic            div_valid = 1'b0;
  logic [1:0]      div_signed = 2'b00;
  logic            div_quotient = 1'b0;
  logic            inst_32 = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [2:0]      dbg_state;

  mdu_ctrl #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2),
    .mul_valid(mul_valid), .mul_signed(mul_signed), .mul_res_lo(mul_res_lo),
    .div_valid(div_valid), .div_signed(div_signed), .div_quotient(div_quotient),
    .inst_32(inst_32),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];

`ifdef MDU_FAST_ZERO_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 67;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // reference model built on native wide arithmetic
  task automatic ref_op(input logic is_mul, input logic [1:0] sg, input logic lo_q,
                        input logic w32, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    logic [63:0] ae, be, q, r;
    logic signed [129:0] pa, pb, pr;
    ae  = w32 ? (sg[1] ? sx32(a) : {32'd0, a[31:0]}) : a;
    be  = w32 ? (sg[0] ? sx32(b) : {32'd0, b[31:0]}) : b;
    lat = w32 ? 35 : 67;
    if (is_mul) begin
      pa  = sg[1] ? {{66{ae[63]}}, ae} : {66'd0, ae};
      pb  = sg[0] ? {{66{be[63]}}, be} : {66'd0, be};
      pr  = pa * pb;
      res = lo_q ? pr[63:0] : pr[127:64];
`ifdef MDU_FAST_ZERO_EN
      if (ae == 0 || be == 0) lat = 2;
`endif
    end else begin
      if (be == 0) begin
        q = '1; r = ae; lat = 2;
      end else if (sg[1] && ae == (w32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000) && be == '1) begin
        q = ae; r = '0; lat = 2;
      end else if (sg[1]) begin
        q = $signed(ae) / $signed(be);
        r = $signed(ae) % $signed(be);
      end else begin
        q = ae / be;
        r = ae % be;
      end
`ifdef MDU_FAST_ZERO_EN
      if (ae == 0 && be != 0) lat = 2;
`endif
      res = lo_q ? q : r;
    end
    if (w32) res = sx32(res);
  endtask

  // driver: one request; lo_q doubles as mul_res_lo / div_quotient
  task automatic drive(input logic is_mul, input logic [1:0] sg, input logic lo_q, input logic w32,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
    @(negedge clk);
    in_valid = 1'b1; mul_valid = is_mul; div_valid = ~is_mul;
    mul_signed = sg; div_signed = sg; mul_res_lo = lo_q; div_quotient = lo_q;
    inst_32 = w32; src1 = a; src2 = b;
    @(posedge clk);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    #1;
    in_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0;
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
  endtask

  // wait for out_valid (bounded), check latency/result, optionally stall, then accept
  task automatic collect(input string tag, input int hold);
    int k;
    logic [63:0] e;
    int l;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 200);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check({tag, " latency"}, 64'(k), 64'(l));
    check({tag, " result"}, result, e);
    repeat (hold) begin
      @(negedge clk);
      check({tag, " hold result"}, result, e);
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, " idle after accept"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic run_dir(input string tag, input logic is_mul, input logic [1:0] sg, input logic lo_q,
                         input logic w32, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat, input int hold);
    drive(is_mul, sg, lo_q, w32, a, b, exp, lat);
    collect(tag, hold);
  endtask

  initial begin
    logic [63:0] e;
    int l;
    logic seen;

    // reset values while rst_n is held low
    #2;
    check("rst result", result, 64'd0);
    check("rst flags", {60'd0, out_valid, busy, in_ready, 1'b0}, 64'h2);
    check("rst state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    // directed operations
    run_dir("mul 7*-3",      1'b1, 2'b11, 1'b1, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 67, 0);
    run_dir("mulhu max",     1'b1, 2'b00, 1'b0, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 67, 5);
    run_dir("divw ovf",      1'b0, 2'b11, 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, 0);
    run_dir("remw ovf",      1'b0, 2'b11, 1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 2, 0);
    run_dir("divu by 0",     1'b0, 2'b00, 1'b1, 1'b0, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_dir("rem -7 by 0",   1'b0, 2'b11, 1'b0, 1'b0, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 2, 0);
    run_dir("rem -7 by 2",   1'b0, 2'b11, 1'b0, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
    run_dir("div -100/7",    1'b0, 2'b11, 1'b1, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 67, 0);
    run_dir("divuw sext",    1'b0, 2'b00, 1'b1, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0);
    run_dir("mulw",          1'b1, 2'b11, 1'b1, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35, 0);
    run_dir("mulhsu -1*2",   1'b1, 2'b10, 1'b0, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
    run_dir("mul zero",      1'b1, 2'b11, 1'b1, 1'b0, 64'd0, 64'd5, 64'd0, ZERO_LAT, 0);
    run_dir("div zero/3",    1'b0, 2'b11, 1'b1, 1'b0, 64'd0, 64'd3, 64'd0, ZERO_LAT, 0);

    // flush beats start; request with neither op bit is ignored
    @(negedge clk);
    in_valid = 1'b1; mul_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; mul_valid = 1'b0;
    check("flush beats start", 64'(busy), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("no-op request ignored", 64'(busy), 64'd0);

    // flush during ITER: no result ever appears
    drive(1'b1, 2'b00, 1'b1, 1'b0, 64'd99, 64'd3, 64'd297, 67);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    repeat (5) @(negedge clk);
    check("in ITER before flush", 64'(dbg_state), 64'd2);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush -> idle", {62'd0, busy, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no out_valid after flush", 64'(seen), 64'd0);
    run_dir("after flush", 1'b1, 2'b00, 1'b1, 1'b0, 64'd99, 64'd3, 64'd297, 67, 0);

    // flush beats out_ready in DONE
    drive(1'b0, 2'b00, 1'b1, 1'b0, 64'd10, 64'd0, '1, 2);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    check("done before flush", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    check("flush in DONE", {62'd0, out_valid, busy}, 64'd0);

    // asynchronous reset mid-ITER (previous result is nonzero)
    run_dir("pre-reset", 1'b1, 2'b00, 1'b1, 1'b0, 64'd6, 64'd7, 64'd42, 67, 0);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 64'd5, 64'd5, 64'd25, 67);
    exp_q.delete();
    lat_q.delete();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst result", result, 64'd0);
    check("async rst flags", {61'd0, out_valid, busy, in_ready}, 64'd1);
    check("async rst state", 64'(dbg_state), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_dir("after reset", 1'b0, 2'b00, 1'b0, 1'b0, 64'd100, 64'd7, 64'd2, 67, 0);

    // random operations against the reference model
    for (int i = 0; i < 14; i++) begin
      logic is_mul, lo_q, w32, s;
      logic [1:0] sg;
      logic [63:0] a, b;
      is_mul = 1'($urandom_range(0, 1));
      lo_q   = 1'($urandom_range(0, 1));
      w32    = 1'($urandom_range(0, 1));
      s      = 1'($urandom_range(0, 1));
      sg     = is_mul ? 2'($urandom_range(0, 3)) : {s, s};
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) b = 64'($urandom_range(1, 50));
      if ($urandom_range(0, 3) == 0) a = -64'($urandom_range(0, 1000));
      ref_op(is_mul, sg, lo_q, w32, a, b, e, l);
      drive(is_mul, sg, lo_q, w32, a, b, e, l);
      collect($sformatf("rand%0d", i), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
